seq_detect_prog: RTL and testbench

//  Runtime-programmable serial sequence detector: finds a pattern of 1..MAX_LEN bits.
//  - Pattern, length and overlap mode are loaded at run time; no hard-coded FSM.
//  - Bit input is qualified by a valid strobe and an enable.
//  - Outputs: a one-cycle match pulse plus a saturating match counter.
//  - Sits on the serial link beside the framer; drives frame-sync and the status block.

---
 rtl/seq_detect_pkg.sv | 14 +
 rtl/seq_shift_cmp.sv | 56 +++++
 rtl/seq_detect_prog.sv | 118 +++++++++++
 tb/tb_seq_detect_prog.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared definitions for the programmable serial sequence detector.
// Holds the FSM state encoding and the config-length width helper.
package seq_detect_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_ARMED = 2'd2;

   // Width needed to hold a length value in 0..max_len
   function automatic int unsigned calc_lw(input int unsigned max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/seq_shift_cmp.sv
// History shift register, fill counter and length-masked pattern compare.
// hit/reach describe the history as it would be after shifting in bit_in.
module seq_shift_cmp
   import seq_detect_pkg::*;
#(
   parameter  int unsigned MAX_LEN = 8,
   localparam int unsigned LW      = calc_lw(MAX_LEN)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               shift,
   input  logic               bit_in,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LW-1:0]      len,
   output logic               hit,
   output logic               reach
);

   logic [MAX_LEN-1:0] hist;
   logic [MAX_LEN-1:0] next_hist;
   logic [LW-1:0]      fill;
   logic [LW:0]        fill_inc;
   logic               mism;

   always_comb begin
      next_hist = MAX_LEN'({hist, bit_in});
      fill_inc  = {1'b0, fill} + (LW+1)'(1);
      reach     = fill_inc >= {1'b0, len};
      mism      = 1'b0;
      // Only the low len bits take part in the compare
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         if (i < 32'(len)) begin
            mism = mism | (next_hist[i] ^ pattern[i]);
         end
      end
      hit = !mism && reach;
   end

   // clr outranks a same-cycle shift
   always_ff @(posedge clk) begin
      if (rst) begin
         hist <= '0;
         fill <= '0;
      end else if (clr) begin
         hist <= '0;
         fill <= '0;
      end else if (shift) begin
         hist <= next_hist;
         if (fill != LW'(MAX_LEN)) begin
            fill <= fill + LW'(1);
         end
      end
   end

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial sequence detector with one-cycle match pulse
// and a saturating match counter.
module seq_detect_prog
   import seq_detect_pkg::*;
#(
   parameter  int unsigned MAX_LEN   = 8,
   parameter  int unsigned CNT_WIDTH = 8,
   localparam int unsigned LW        = calc_lw(MAX_LEN)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_load,
   input  logic [MAX_LEN-1:0]   cfg_pattern,
   input  logic [LW-1:0]        cfg_len,
   input  logic                 cfg_overlap,
   input  logic                 en,
   input  logic                 bit_vld,
   input  logic                 bit_in,
   input  logic                 cnt_clr,
   output logic                 match,
   output logic [CNT_WIDTH-1:0] match_cnt,
   output logic                 armed,
   output logic                 cfg_err
);

   logic [1:0]         state;
   logic [1:0]         state_nxt;
   logic [MAX_LEN-1:0] pattern_q;
   logic [LW-1:0]      len_q;
   logic               overlap_q;
   logic               cfg_ok;
   logic               accept;
   logic               hist_clr;
   logic               match_nxt;
   logic               cfg_err_nxt;
   logic               hit;
   logic               reach;

   seq_shift_cmp #(
      .MAX_LEN (MAX_LEN)
   ) u_shift_cmp (
      .clk     (clk),
      .rst     (rst),
      .clr     (hist_clr),
      .shift   (accept),
      .bit_in  (bit_in),
      .pattern (pattern_q),
      .len     (len_q),
      .hit     (hit),
      .reach   (reach)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, history clear and registered-output next values
   always_comb begin
      state_nxt   = state;
      match_nxt   = 1'b0;
      hist_clr    = 1'b0;
      cfg_err_nxt = cfg_err;
      cfg_ok      = (cfg_len != '0) && (32'(cfg_len) <= MAX_LEN);
      accept      = en && bit_vld && !cfg_load && (state != ST_IDLE);

      if (cfg_load) begin
         hist_clr    = 1'b1;
         cfg_err_nxt = !cfg_ok;
         state_nxt   = cfg_ok ? ST_FILL : ST_IDLE;
      end else if (accept) begin
         match_nxt = hit;
         case (state)
            ST_FILL, ST_ARMED: begin
               if (hit && !overlap_q) begin
                  // Non-overlapping: restart collection; a 1-bit pattern never needs refill
                  hist_clr  = 1'b1;
                  state_nxt = (len_q == LW'(1)) ? ST_ARMED : ST_FILL;
               end else if (reach) begin
                  state_nxt = ST_ARMED;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pattern_q <= '0;
         len_q     <= '0;
         overlap_q <= 1'b0;
         match     <= 1'b0;
         match_cnt <= '0;
         armed     <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         if (cfg_load && cfg_ok) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len;
            overlap_q <= cfg_overlap;
         end
         match   <= match_nxt;
         armed   <= (state_nxt == ST_ARMED);
         cfg_err <= cfg_err_nxt;
         // Clear outranks a same-cycle increment; count saturates
         if (cnt_clr) begin
            match_cnt <= '0;
         end else if (match_nxt && (match_cnt != '1)) begin
            match_cnt <= match_cnt + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog: two instances (8-bit and 2-bit counters)
// share stimulus; expected match pulses are queued and checked by a monitor.
module tb_seq_detect_prog;

   typedef struct {
      int cyc;
      int cnt;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       cfg_load;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       en;
   logic       bit_vld;
   logic       bit_in;
   logic       cnt_clr;
   logic       match1, match2;
   logic [7:0] cnt1;
   logic [1:0] cnt2;
   logic       armed1, armed2;
   logic       cfg_err1, cfg_err2;

   exp_t q1[$];
   exp_t q2[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   m1 = 0;
   int   m2 = 0;
   bit   mon_en = 0;

   seq_detect_prog #(.MAX_LEN(8), .CNT_WIDTH(8)) dut1 (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .en(en), .bit_vld(bit_vld),
      .bit_in(bit_in), .cnt_clr(cnt_clr), .match(match1), .match_cnt(cnt1),
      .armed(armed1), .cfg_err(cfg_err1));

   seq_detect_prog #(.MAX_LEN(8), .CNT_WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .en(en), .bit_vld(bit_vld),
      .bit_in(bit_in), .cnt_clr(cnt_clr), .match(match2), .match_cnt(cnt2),
      .armed(armed2), .cfg_err(cfg_err2));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic mon(input int id, input logic m, input logic [7:0] c);
      exp_t h;
      bit   have;
      have = 0;
      if (id == 0 && q1.size() > 0 && q1[0].cyc == cyc) begin h = q1.pop_front(); have = 1; end
      if (id == 1 && q2.size() > 0 && q2[0].cyc == cyc) begin h = q2.pop_front(); have = 1; end
      checks++;
      if (m !== have) begin
         failures++;
         $display("FAIL match[dut%0d] cyc=%0d got=%b want=%b", id + 1, cyc, m, have);
      end else if (have) begin
         checks++;
         if (c !== 8'(h.cnt)) begin
            failures++;
            $display("FAIL match_cnt_on_pulse[dut%0d] cyc=%0d got=%0d want=%0d", id + 1, cyc, c, h.cnt);
         end
      end
   endtask

   // Monitor: every cycle, a pulse must line up exactly with a queued expectation
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (mon_en) begin
            mon(0, match1, cnt1);
            mon(1, match2, 8'(cnt2));
         end
      end
   end

   task automatic step(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                       input logic ov, input logic e, input logic v, input logic b,
                       input logic clr, input logic expm);
      exp_t x;
      @(negedge clk);
      cfg_load = ld; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
      en = e; bit_vld = v; bit_in = b; cnt_clr = clr;
      if (clr) begin
         m1 = 0; m2 = 0;
      end else if (expm) begin
         if (m1 < 255) m1++;
         if (m2 < 3) m2++;
      end
      if (expm) begin
         x.cyc = cyc + 1; x.cnt = m1; q1.push_back(x);
         x.cnt = m2; q2.push_back(x);
      end
   endtask

   task automatic bitx(input logic b, input logic expm);
      step(0, 8'h00, 4'd0, 0, 1, 1, b, 0, expm);
   endtask

   task automatic idle();
      step(0, 8'h00, 4'd0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic gap(input logic e, input logic v, input logic b);
      step(0, 8'h00, 4'd0, 0, e, v, b, 0, 0);
   endtask

   task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov);
      step(1, pat, len, ov, 0, 0, 0, 0, 0);
   endtask

   task automatic clrc();
      step(0, 8'h00, 4'd0, 0, 0, 0, 0, 1, 0);
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", name, got, exp);
      end
   endtask

   initial begin
      logic [7:0] p;
      rst = 1; cfg_load = 0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
      en = 0; bit_vld = 0; bit_in = 0; cnt_clr = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      mon_en = 1;
      chk("reset_match", 8'(match1), 8'd0);
      chk("reset_armed", 8'(armed1), 8'd0);
      chk("reset_cfg_err", 8'(cfg_err1), 8'd0);
      chk("reset_cnt", cnt1, 8'd0);
      chk("reset_cnt2", 8'(cnt2), 8'd0);

      // 1: unconfigured, bits ignored
      repeat (4) bitx(1, 0);
      idle();
      chk("t1_armed", 8'(armed1), 8'd0);
      chk("t1_cfg_err", 8'(cfg_err1), 8'd0);
      chk("t1_cnt", cnt1, 8'd0);

      // 2: 1011 overlapping over 1,0,1,1,0,1,1
      load(8'b0000_1011, 4'd4, 1);
      idle();
      chk("t2_cfg_err", 8'(cfg_err1), 8'd0);
      bitx(1, 0); bitx(0, 0); bitx(1, 0);
      idle();
      chk("t2_armed_before", 8'(armed1), 8'd0);
      bitx(1, 1);
      idle();
      chk("t2_armed_after", 8'(armed1), 8'd1);
      bitx(0, 0); bitx(1, 0); bitx(1, 1);
      idle();
      chk("t2_cnt", cnt1, 8'd2);
      chk("t2_cnt2", 8'(cnt2), 8'd2);

      // 3: same stream, non-overlapping
      clrc();
      load(8'b0000_1011, 4'd4, 0);
      bitx(1, 0); bitx(0, 0); bitx(1, 0); bitx(1, 1);
      bitx(0, 0); bitx(1, 0); bitx(1, 0);
      idle();
      chk("t3_cnt", cnt1, 8'd1);
      chk("t3_armed", 8'(armed1), 8'd0);

      // 4: illegal lengths, then a legal load
      clrc();
      load(8'b0000_1011, 4'd0, 1);
      idle();
      chk("t4_err_len0", 8'(cfg_err1), 8'd1);
      chk("t4_armed_len0", 8'(armed1), 8'd0);
      bitx(1, 0); bitx(0, 0); bitx(1, 0); bitx(1, 0);
      idle();
      chk("t4_err_hold", 8'(cfg_err1), 8'd1);
      load(8'b0000_1011, 4'd9, 1);
      idle();
      chk("t4_err_len9", 8'(cfg_err1), 8'd1);
      bitx(1, 0); bitx(0, 0); bitx(1, 0); bitx(1, 0);
      idle();
      chk("t4_armed_len9", 8'(armed1), 8'd0);
      load(8'b0000_1011, 4'd4, 1);
      idle();
      chk("t4_err_clear", 8'(cfg_err1), 8'd0);
      chk("t4_cnt", cnt1, 8'd0);

      // 5a: cfg_load with a coincident bit drops the bit and restarts history
      bitx(1, 0); bitx(0, 0); bitx(1, 0);
      step(1, 8'b0000_1011, 4'd4, 1, 1, 1, 1, 0, 0);
      bitx(0, 0); bitx(1, 0); bitx(1, 0); bitx(1, 0);
      bitx(0, 0); bitx(1, 0); bitx(1, 1);
      idle();
      chk("t5_drop_cnt", cnt1, 8'd1);

      // 5b: full-length pattern with en/bit_vld bubbles between bits
      clrc();
      p = 8'hCA;
      load(p, 4'd8, 1);
      for (int i = 7; i >= 0; i--) begin
         bitx(p[i], i == 0);
         if (i != 0) begin
            gap(0, 1, !p[i]);
            gap(1, 0, !p[i]);
         end
      end
      idle();
      chk("t5_gap_cnt", cnt1, 8'd1);
      chk("t5_gap_armed", 8'(armed1), 8'd1);

      // 6: counter saturation on the 2-bit instance, clear beats increment
      clrc();
      load(8'b0000_0001, 4'd1, 1);
      idle();
      chk("t6_armed_pre", 8'(armed1), 8'd0);
      repeat (5) bitx(1, 1);
      idle();
      chk("t6_cnt", cnt1, 8'd5);
      chk("t6_cnt2_sat", 8'(cnt2), 8'd3);
      step(0, 8'h00, 4'd0, 0, 1, 1, 1, 1, 1);
      idle();
      chk("t6_clr_cnt", cnt1, 8'd0);
      chk("t6_clr_cnt2", 8'(cnt2), 8'd0);

      // 6b: single-bit pattern, non-overlapping, stays armed
      load(8'b0000_0001, 4'd1, 0);
      bitx(1, 1); bitx(1, 1); bitx(0, 0); bitx(1, 1);
      idle();
      chk("t6_len1_armed", 8'(armed1), 8'd1);
      chk("t6_len1_cnt", cnt1, 8'd3);
      chk("t6_len1_cnt2", 8'(cnt2), 8'd3);

      repeat (3) idle();
      chk("queue1_drained", 8'(q1.size()), 8'd0);
      chk("queue2_drained", 8'(q2.size()), 8'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
